ws2812_rx: RTL and testbench

Single-wire WS2812 receiver/decoder: the pixel-side counterpart of the ws2812 transmit IP. It samples the serial data line and classifies each high pulse as a 0 or 1 bit by its width. It assembles 24-bit GRB pixel words and detects the low-time reset/latch gap. After capturing its own pixel it forwards the remaining bitstream downstream, so instances can be daisy-chained. It serves as a checker/loopback target in IP-level benches and as a synthesizable pixel model on the board.

---
 rtl/ws2812_pkg.sv | 23 ++
 rtl/ws2812_sync.sv | 27 ++
 rtl/ws2812_rx.sv | 192 +++++++++++++++++++
 tb/tb_ws2812_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and helpers for the WS2812 receive path.
// Holds the pixel word type, the decoder state encoding and the
// nanosecond-to-cycle conversion used for every timing constant.
package ws2812_pkg;

    localparam int WS2812_BITS = 24;

    // One pixel word, GRB order, MSB first on the wire.
    typedef logic [WS2812_BITS-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    // Cycles covered by a duration in ns, truncated.
    function automatic int ns2cyc(input int ns, input int clk_hz);
        return (ns * (clk_hz / 1_000_000)) / 1000;
    endfunction

endpackage

// File: rtl/ws2812_sync.sv
// ws2812_sync: two-flop synchronizer for an asynchronous line plus
// single-cycle rise/fall strobes taken from the synchronized value.
// The flops carry no reset on purpose: they keep following the line
// through a reset, so a level already present at reset release never
// shows up as a fresh edge.
module ws2812_sync (
    input  logic clk,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    // Metastability chain and one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        sync_reg <= {sync_reg[0], d};
        prev_reg <= sync_reg[1];
    end

    assign q    = sync_reg[1];
    assign rise = sync_reg[1] & ~prev_reg;
    assign fall = ~sync_reg[1] & prev_reg;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire pixel receiver.
// Classifies each high pulse by width, assembles 24-bit GRB words,
// detects the low reset gap (latch) and flags protocol errors.
// Build option WS2812_RX_FWD_EN: when defined, the first pixel of a frame
// is kept and the rest of the stream is forwarded on dout for a
// daisy-chained pixel; when undefined, dout is 0 and every further
// 24 bits produce another pixel_valid (whole-frame stream decoder).
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int BIT_THRESH_NS = 625,
    parameter int MIN_HIGH_NS   = 150,
    parameter int RESET_NS      = 50_000
) (
    input  logic   ACLK,
    input  logic   ARESET,
    input  logic   din,
    output logic   dout,
    output pixel_t pixel_data,
    output logic   pixel_valid,
    output logic   latch,
    output logic   frame_err
);

    localparam int THRESH   = ns2cyc(BIT_THRESH_NS, CLK_HZ);
    localparam int MIN_HIGH = ns2cyc(MIN_HIGH_NS, CLK_HZ);
    localparam int RST      = ns2cyc(RESET_NS, CLK_HZ);
    localparam int CW       = $clog2(RST + 1);
    localparam int BW       = $clog2(WS2812_BITS + 1);

    localparam logic [CW-1:0] THRESH_C   = CW'(THRESH);
    localparam logic [CW-1:0] MIN_HIGH_C = CW'(MIN_HIGH);
    localparam logic [CW-1:0] RST_C      = CW'(RST);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WS2812_BITS - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_HIGH  = HIGH;
    localparam logic [1:0] ST_LOW   = LOW;
    localparam logic [1:0] ST_STUCK = STUCK;

    logic          din_s, din_rise, din_fall;
    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    pixel_t        shift_reg, shift_next, shifted;
    pixel_t        pixel_data_reg, pixel_data_next;
    logic          pixel_valid_reg, pixel_valid_next;
    logic          latch_reg, latch_next;
    logic          frame_err_reg, frame_err_next;
    logic          fwd_reg;

    ws2812_sync u_sync (
        .clk  (ACLK),
        .d    (din),
        .q    (din_s),
        .rise (din_rise),
        .fall (din_fall)
    );

    // Width counter never wraps; it holds at the reset-gap length.
    assign cnt_inc = (cnt_reg == RST_C) ? cnt_reg : cnt_reg + ONE_C;
    assign shifted = {shift_reg[WS2812_BITS-2:0], (cnt_reg >= THRESH_C)};

    // Pulse-width decoder: next state, counters and event strobes.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        pixel_data_next  = pixel_data_reg;
        pixel_valid_next = 1'b0;
        latch_next       = 1'b0;
        frame_err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (din_rise) begin
                    state_next = ST_HIGH;
                    cnt_next   = ONE_C;
                end
            end
            ST_HIGH: begin
                if (din_fall) begin
                    state_next = ST_LOW;
                    cnt_next   = ONE_C;
                    // Glitches are dropped; while forwarding, bits are not ours.
                    if (cnt_reg >= MIN_HIGH_C && !fwd_reg) begin
                        shift_next = shifted;
                        if (bit_cnt_reg == LAST_BIT) begin
                            pixel_data_next  = shifted;
                            pixel_valid_next = 1'b1;
                            bit_cnt_next     = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end else if (cnt_inc == RST_C) begin
                    state_next     = ST_STUCK;
                    cnt_next       = cnt_inc;
                    frame_err_next = 1'b1;
                    bit_cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_LOW: begin
                // In LOW any high sample is a rising edge.
                if (din_s) begin
                    state_next = ST_HIGH;
                    cnt_next   = ONE_C;
                end else if (cnt_inc == RST_C) begin
                    state_next     = ST_IDLE;
                    cnt_next       = '0;
                    latch_next     = 1'b1;
                    frame_err_next = (bit_cnt_reg != '0);
                    bit_cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_STUCK: begin
                if (din_fall) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Decoder state and registered outputs; reset overrides every event.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            pixel_data_reg  <= '0;
            pixel_valid_reg <= 1'b0;
            latch_reg       <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            pixel_data_reg  <= pixel_data_next;
            pixel_valid_reg <= pixel_valid_next;
            latch_reg       <= latch_next;
            frame_err_reg   <= frame_err_next;
        end
    end

`ifdef WS2812_RX_FWD_EN
    logic dout_reg;

    // Forward flag: set once our own pixel is captured, cleared at frame end or stuck line.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            fwd_reg <= 1'b0;
        end else if (pixel_valid_next) begin
            fwd_reg <= 1'b1;
        end else if (latch_next || frame_err_next) begin
            fwd_reg <= 1'b0;
        end
    end

    // Downstream copy of the synchronized line while forwarding.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            dout_reg <= 1'b0;
        end else begin
            dout_reg <= fwd_reg ? din_s : 1'b0;
        end
    end

    assign dout = dout_reg;
`else
    assign fwd_reg = 1'b0;
    assign dout    = 1'b0;
`endif

    assign pixel_data  = pixel_data_reg;
    assign pixel_valid = pixel_valid_reg;
    assign latch       = latch_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx at 100 MHz, default parameters.
// A whole-run din/reset timeline is built first; a pulse-level model then
// derives the expected outputs for every clock edge from the run lengths
// of that timeline, and one loop drives the DUT and compares every cycle.
module tb_ws2812_rx;

    localparam int NCYC = 72500;
    localparam int THR  = 62;
    localparam int MINH = 15;
    localparam int RST  = 5000;
`ifdef WS2812_RX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        din;
    logic        dout;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        latch;
    logic        frame_err;

    ws2812_rx dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .din         (din),
        .dout        (dout),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .latch       (latch),
        .frame_err   (frame_err)
    );

    always #5 ACLK = ~ACLK;

    // Timeline: din and ARESET as seen at rising edge e.
    bit          x_tl   [NCYC];
    bit          rst_tl [NCYC];
    // Expected outputs just after rising edge e.
    bit          exp_pv    [NCYC];
    bit          exp_latch [NCYC];
    bit          exp_err   [NCYC];
    bit          exp_dout  [NCYC];
    logic [23:0] exp_pvd   [NCYC];
    logic [23:0] exp_pd    [NCYC];

    int pos;
    int mid_rst;
    int n_pass = 0;
    int n_chk  = 0;
    logic [23:0] lit_px [$];

    task automatic check(input bit ok, input string what, input string got, input string want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", what, got, want);
    endtask

    task automatic put(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            if (pos < NCYC) x_tl[pos] = lvl;
            pos++;
        end
    endtask

    // 1 = 800 ns high / 450 ns low, 0 = 400 ns high / 850 ns low.
    task automatic put_bit(input bit b);
        if (b) begin put(1'b1, 80); put(1'b0, 45); end
        else   begin put(1'b1, 40); put(1'b0, 85); end
    endtask

    task automatic put_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) put_bit(w[i]);
    endtask

    task automatic build();
        logic [23:0] w;
        logic [9:0]  tb10;
        pos = 0;
        for (int i = 0; i < NCYC; i++) begin x_tl[i] = 1'b0; rst_tl[i] = 1'b0; end
        for (int i = 0; i < 10; i++) rst_tl[i] = 1'b1;
        put(1'b0, 30);
        put_word(24'hA53C0F); put(1'b0, 6000);
        put_word(24'h123456); put_word(24'hFFFFFF); put(1'b0, 6000);
        // Boundary widths: 61-cycle high = 0, 63-cycle high = 1, 10-cycle glitch ignored.
        w = 24'h5AC396;
        put(1'b1, 61); put(1'b0, 64);
        put(1'b1, 63); put(1'b0, 62);
        put_bit(w[21]);
        put(1'b1, 10); put(1'b0, 45);
        for (int i = 20; i >= 0; i--) put_bit(w[i]);
        put(1'b0, 6000);
        // Short frame: 10 bits then the gap.
        tb10 = 10'b1011001110;
        for (int i = 9; i >= 0; i--) put_bit(tb10[i]);
        put(1'b0, 6000);
        put_word(24'h00FF00); put(1'b0, 6000);
        // Line stuck high, then recovery.
        put(1'b1, 6000); put(1'b0, 100);
        put_word(24'hC0FFEE); put(1'b0, 6000);
        // Reset for 2 cycles inside the high part of bit 13.
        w = 24'hABCDEF;
        for (int i = 23; i >= 12; i--) put_bit(w[i]);
        mid_rst = pos + 20;
        rst_tl[mid_rst] = 1'b1; rst_tl[mid_rst+1] = 1'b1;
        put(1'b1, 80); put(1'b0, 45);
        put_word(24'h0F1E2D); put(1'b0, 6000);
    endtask

    task automatic close_fwd(input int a, input int b);
        for (int e = a + 1; e <= b; e++) exp_dout[e] = x_tl[e-2];
    endtask

    // Walk the runs of equal din samples j0..j1 (sample j shows at edge j+2).
    task automatic model_window(input int j0, input int j1);
        int j, n, k, bits, fwd_from;
        bit gap, fwd;
        logic [23:0] sh;
        gap = 0; fwd = 0; bits = 0; sh = '0; fwd_from = 0;
        j = j0;
        // A level already present when the window opens is inert.
        while (j <= j1 && x_tl[j] == x_tl[j0-1]) j++;
        while (j <= j1) begin
            n = 0;
            while (j + n <= j1 && x_tl[j+n] == x_tl[j]) n++;
            if (x_tl[j]) begin
                if (n >= RST) begin
                    k = j + RST - 1;
                    exp_err[k+2] = 1'b1;
                    if (fwd) close_fwd(fwd_from, k + 2);
                    fwd = 0; bits = 0; gap = 0;
                end else if (j + n <= j1) begin
                    k = j + n;
                    gap = 1;
                    if (n >= MINH && !fwd) begin
                        sh = {sh[22:0], (n >= THR)};
                        bits++;
                        if (bits == 24) begin
                            exp_pv[k+2]  = 1'b1;
                            exp_pvd[k+2] = sh;
                            bits = 0;
                            if (FWD) begin fwd = 1; fwd_from = k + 2; end
                        end
                    end
                end
            end else if (gap && n >= RST) begin
                k = j + RST - 1;
                exp_latch[k+2] = 1'b1;
                if (bits != 0) exp_err[k+2] = 1'b1;
                if (fwd) close_fwd(fwd_from, k + 2);
                fwd = 0; bits = 0; gap = 0;
            end
            j += n;
        end
        if (fwd) close_fwd(fwd_from, j1 + 2);
    endtask

    task automatic run_model();
        int rs_q[$], re_q[$];
        logic [23:0] pd;
        for (int e = 0; e < NCYC; e++) begin
            exp_pv[e] = 0; exp_latch[e] = 0; exp_err[e] = 0; exp_dout[e] = 0; exp_pvd[e] = '0;
            if (rst_tl[e] && (e == 0 || !rst_tl[e-1])) rs_q.push_back(e);
            if (rst_tl[e] && (e == NCYC - 1 || !rst_tl[e+1])) re_q.push_back(e);
        end
        for (int i = 0; i < re_q.size(); i++)
            model_window(re_q[i] - 1, (i + 1 < rs_q.size()) ? rs_q[i+1] - 3 : NCYC - 3);
        pd = '0;
        for (int e = 0; e < NCYC; e++) begin
            if (rst_tl[e]) pd = '0;
            else if (exp_pv[e]) pd = exp_pvd[e];
            exp_pd[e] = pd;
        end
    endtask

    initial begin
        logic [23:0] m_px[$], d_px[$];
        int m_first_pv, m_first_latch, m_latch, m_err;
        int n_latch, n_err, n_err_latch, n_dout_early;
        logic [23:0] pd_after_rst;
        bit ok;

        lit_px = {24'hA53C0F, 24'h123456};
`ifndef WS2812_RX_FWD_EN
        lit_px.push_back(24'hFFFFFF);
`endif
        lit_px.push_back(24'h5AC396);
        lit_px.push_back(24'h00FF00);
        lit_px.push_back(24'hC0FFEE);
        lit_px.push_back(24'h0F1E2D);

        din = 1'b0; ARESET = 1'b1;
        build();
        run_model();

        // Pin the model against hand-computed values.
        m_first_pv = -1; m_first_latch = -1; m_latch = 0; m_err = 0;
        for (int e = 0; e < NCYC; e++) begin
            if (exp_pv[e]) begin m_px.push_back(exp_pvd[e]); if (m_first_pv < 0) m_first_pv = e; end
            if (exp_latch[e]) begin m_latch++; if (m_first_latch < 0) m_first_latch = e; end
            if (exp_err[e]) m_err++;
        end
        check(m_first_pv == 2987, "model_first_pv_edge", $sformatf("%0d", m_first_pv), "2987");
        check(m_first_latch == 7986, "model_first_latch_edge", $sformatf("%0d", m_first_latch), "7986");
        check(m_latch == 7, "model_latch_count", $sformatf("%0d", m_latch), "7");
        check(m_err == 2, "model_err_count", $sformatf("%0d", m_err), "2");
        check(m_px.size() == lit_px.size(), "model_pixel_count",
              $sformatf("%0d", m_px.size()), $sformatf("%0d", lit_px.size()));
        for (int i = 0; i < lit_px.size(); i++)
            if (i < m_px.size())
                check(m_px[i] == lit_px[i], $sformatf("model_pixel_%0d", i),
                      $sformatf("%h", m_px[i]), $sformatf("%h", lit_px[i]));

        // Drive the timeline and compare every cycle.
        n_latch = 0; n_err = 0; n_err_latch = 0; n_dout_early = 0; pd_after_rst = 24'hFFFFFF;
        for (int e = 0; e < NCYC; e++) begin
            din = x_tl[e];
            ARESET = rst_tl[e];
            @(posedge ACLK);
            #1;
            ok = (pixel_valid === exp_pv[e]) && (latch === exp_latch[e]) && (frame_err === exp_err[e])
                 && (dout === exp_dout[e]) && (pixel_data === exp_pd[e]);
            n_chk++;
            if (ok) n_pass++;
            else $display("FAIL cycle_%0d: got pv=%b latch=%b err=%b dout=%b data=%h, expected pv=%b latch=%b err=%b dout=%b data=%h",
                          e, pixel_valid, latch, frame_err, dout, pixel_data,
                          exp_pv[e], exp_latch[e], exp_err[e], exp_dout[e], exp_pd[e]);
            $display("cycle %0d din=%b rst=%b pv=%b latch=%b err=%b dout=%b data=%h",
                     e, x_tl[e], rst_tl[e], pixel_valid, latch, frame_err, dout, pixel_data);
            if (pixel_valid) d_px.push_back(pixel_data);
            if (latch) n_latch++;
            if (frame_err) begin n_err++; if (latch) n_err_latch++; end
            if (dout && e < 7986) n_dout_early++;
            if (e == mid_rst + 1) pd_after_rst = pixel_data;
        end

        // Hand-computed frame-level expectations.
        check(d_px.size() == lit_px.size(), "pixel_count",
              $sformatf("%0d", d_px.size()), $sformatf("%0d", lit_px.size()));
        for (int i = 0; i < lit_px.size(); i++)
            if (i < d_px.size())
                check(d_px[i] == lit_px[i], $sformatf("pixel_%0d", i),
                      $sformatf("%h", d_px[i]), $sformatf("%h", lit_px[i]));
        check(n_latch == 7, "latch_count", $sformatf("%0d", n_latch), "7");
        check(n_err == 2, "frame_err_count", $sformatf("%0d", n_err), "2");
        check(n_err_latch == 1, "err_with_latch", $sformatf("%0d", n_err_latch), "1");
        check(n_dout_early == 0, "dout_first_frame", $sformatf("%0d", n_dout_early), "0");
        check(pd_after_rst == 24'h0, "pixel_data_after_reset", $sformatf("%h", pd_after_rst), "000000");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
